// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, bounce and binary count on a prescaled tick.
// Optional LED_ACTIVE_LOW_EN inverts the leds pins for active-low boards.
module led_pattern_gen #(
    parameter int LEDS_NR   = 3,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [LEDS_NR-1:0]   leds,
    output logic                 tick
);

    localparam logic [1:0] M_BLINK  = 2'b00;
    localparam logic [1:0] M_CHASE  = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;
    localparam logic [1:0] M_COUNT  = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam logic [LEDS_NR-1:0]   PAT_ONE = LEDS_NR'(1);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEDS_NR-1:0]   pat_q, pat_d;
    logic                 dir_q, dir_d;
    logic                 tick_q, tick_d;

    logic [LEDS_NR-1:0]   pat_nxt;
    logic                 dir_nxt;
    logic                 onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode;
            cnt_q  <= '0;
            pat_q  <= '0;
            dir_q  <= DIR_UP;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    // Pattern step applied when a tick fires
    always_comb begin
        onehot  = (pat_q != '0) && ((pat_q & (pat_q - PAT_ONE)) == '0);
        pat_nxt = pat_q;
        dir_nxt = dir_q;
        unique case (mode_q)
            M_BLINK: pat_nxt = ~pat_q;
            M_CHASE: begin
                if (onehot)
                    pat_nxt = (pat_q << 1) | (pat_q >> (LEDS_NR - 1));
                else
                    pat_nxt = PAT_ONE;
            end
            M_BOUNCE: begin
                if (!onehot) begin
                    pat_nxt = PAT_ONE;
                    dir_nxt = DIR_UP;
                end else if (dir_q == DIR_UP && !pat_q[LEDS_NR-1]) begin
                    pat_nxt = pat_q << 1;
                    dir_nxt = pat_nxt[LEDS_NR-1] ? DIR_DN : DIR_UP;
                end else if (dir_q == DIR_DN && !pat_q[0]) begin
                    pat_nxt = pat_q >> 1;
                    dir_nxt = pat_nxt[0] ? DIR_UP : DIR_DN;
                end
            end
            M_COUNT: pat_nxt = pat_q + PAT_ONE;
            default: pat_nxt = pat_q;
        endcase
    end

    // Mode change restarts, pause holds, otherwise prescale
    always_comb begin
        mode_d = mode;
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (mode != mode_q) begin
            cnt_d = '0;
            pat_d = '0;
            dir_d = DIR_UP;
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                pat_d  = pat_nxt;
                dir_d  = dir_nxt;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

`ifdef LED_ACTIVE_LOW_EN
    assign leds = ~pat_q;
`else
    assign leds = pat_q;
`endif
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised and directed bench for led_pattern_gen against a tick-count reference model.
// Honours LED_ACTIVE_LOW_EN for the expected pin polarity.
module tb_led_pattern_gen;

    localparam int N  = 3;
    localparam int DW = 24;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N-1:0] INV = '1;
`else
    localparam logic [N-1:0] INV = '0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic [N-1:0]  leds;
    logic          tick;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: ticks since restart, prescaler count, tick flag
    int       m_k;
    longint   m_cnt;
    logic     m_tick;
    logic [1:0] m_mode;

    led_pattern_gen #(.LEDS_NR(N), .DIV_WIDTH(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .div  (div),
        .leds (leds),
        .tick (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_pat(input logic [1:0] m, input int k);
        int p;
        int pos;
        case (m)
            2'b00: return (k % 2 == 1) ? '1 : '0;
            2'b01: return (k == 0) ? '0 : N'(1 << ((k - 1) % N));
            2'b10: begin
                if (k == 0) return '0;
                p   = (k - 1) % (2 * (N - 1));
                pos = (p < N) ? p : 2 * (N - 1) - p;
                return N'(1 << pos);
            end
            default: return N'(k % (1 << N));
        endcase
    endfunction

    function automatic logic [N-1:0] pin(input logic [N-1:0] v);
        return v ^ INV;
    endfunction

    task automatic model_step(input logic r, input logic e,
                              input logic [1:0] m, input logic [DW-1:0] d);
        if (r || m != m_mode) begin
            m_k    = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
            m_mode = m;
        end else if (!e) begin
            m_tick = 1'b0;
        end else if (m_cnt == longint'(d)) begin
            m_tick = 1'b1;
            m_cnt  = 0;
            m_k++;
        end else begin
            m_cnt  = (m_cnt + 1) % (longint'(1) << DW);
            m_tick = 1'b0;
        end
    endtask

    task automatic cyc(input logic r, input logic e,
                       input logic [1:0] m, input logic [DW-1:0] d);
        rst  = r;
        en   = e;
        mode = m;
        div  = d;
        @(posedge clk);
        model_step(r, e, m, d);
        @(negedge clk);
        chk("leds", 32'(leds), 32'(pin(exp_pat(m_mode, m_k))));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run_to_tick(input string tag, input int exp_n,
                               input logic [1:0] m, input logic [DW-1:0] d);
        int n;
        n = 0;
        do begin
            cyc(1'b0, 1'b1, m, d);
            n++;
        end while (tick !== 1'b1 && n < 64);
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    logic [N-1:0] bseq [6];
    logic [N-1:0] bexp [6];

    initial begin
        m_k = 0; m_cnt = 0; m_tick = 1'b0; m_mode = 2'b00;

        // reset and first ticks in BLINK, div = 3
        cyc(1'b1, 1'b1, 2'b00, 24'd3);
        chk("rst_leds", 32'(leds), 32'(INV));
        cyc(1'b1, 1'b1, 2'b00, 24'd3);
        chk("rst_tick", 32'(tick), 32'd0);
        run_to_tick("first_tick_lat", 4, 2'b00, 24'd3);
        chk("first_tick_leds", 32'(leds), 32'(pin(3'b111)));
        run_to_tick("second_tick_lat", 4, 2'b00, 24'd3);
        chk("second_tick_leds", 32'(leds), 32'(pin(3'b000)));

        // CHASE wrap, div = 0
        cyc(1'b0, 1'b1, 2'b01, 24'd0);
        chk("chase_restart", 32'(leds), 32'(pin(3'b000)));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'b01, 24'd0);
            chk("chase_tick", 32'(tick), 32'd1);
        end
        chk("chase_wrap", 32'(leds), 32'(pin(3'b001)));

        // BOUNCE turnaround, div = 1
        bexp = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010};
        cyc(1'b0, 1'b1, 2'b10, 24'd1);
        for (int i = 0; i < 6; i++) begin
            run_to_tick("bounce_period", 2, 2'b10, 24'd1);
            bseq[i] = leds ^ INV;
            chk("bounce_seq", 32'(bseq[i]), 32'(bexp[i]));
        end

        // COUNT wrap then pause
        cyc(1'b0, 1'b1, 2'b11, 24'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 2'b11, 24'd0);
        chk("count_wrap", 32'(leds), 32'(pin(3'b000)));
        cyc(1'b0, 1'b1, 2'b11, 24'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 2'b11, 24'd0);
            chk("pause_leds", 32'(leds), 32'(pin(3'b001)));
            chk("pause_tick", 32'(tick), 32'd0);
        end

        // mode change on a tick cycle with leds = 101
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'b11, 24'd0);
        chk("pre_switch", 32'(leds), 32'(pin(3'b101)));
        cyc(1'b0, 1'b1, 2'b01, 24'd0);
        chk("switch_leds", 32'(leds), 32'(pin(3'b000)));
        chk("switch_tick", 32'(tick), 32'd0);
        cyc(1'b0, 1'b1, 2'b01, 24'd0);
        chk("switch_first", 32'(leds), 32'(pin(3'b001)));

        // randomised traffic; div only changes together with a restart
        begin
            logic [1:0]    rm;
            logic [DW-1:0] rd;
            logic          rr;
            rm = 2'b01;
            rd = 24'd0;
            for (int i = 0; i < 3000; i++) begin
                rr = ($urandom_range(0, 99) == 0);
                if (rr || $urandom_range(0, 29) == 0) begin
                    rm = 2'($urandom_range(0, 3));
                    if (rr || rm != m_mode) rd = DW'($urandom_range(0, 5));
                end
                cyc(rr, ($urandom_range(0, 9) < 8), rm, rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
